// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational field/immediate/legality decode registered into a
// two-entry (main + skid) FIFO buffer with valid/ready handshakes on both sides.
module rv32i_decode_stage #(
    parameter int unsigned CHECK_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [31:0] out_imm,
    output logic        out_uses_rs1,
    output logic        out_uses_rs2,
    output logic        out_writes_rd,
    output logic        out_illegal,
    input  logic        flush
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t   state, state_nxt;
    entry_t dec, main_q, skid_q, main_nxt;
    logic   load_main, load_skid, main_from_skid;
    logic   acc, emit;
    logic   bad, u1, u2, wr;
    logic [6:0] op, f7;
    logic [2:0] f3;

    assign op = in_inst[6:0];
    assign f3 = in_inst[14:12];
    assign f7 = in_inst[31:25];

    always_comb begin
        bad     = 1'b0;
        u1      = 1'b0;
        u2      = 1'b0;
        wr      = 1'b0;
        dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
        case (op)
            OPC_OP: begin
                u1  = 1'b1;
                u2  = 1'b1;
                wr  = 1'b1;
                bad = !(f7 == 7'h00 || f7 == 7'h20) ||
                      (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
            end
            OPC_IMM: begin
                u1  = 1'b1;
                wr  = 1'b1;
                bad = (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
            end
            OPC_LOAD: begin
                u1  = 1'b1;
                wr  = 1'b1;
                bad = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                u1      = 1'b1;
                u2      = 1'b1;
                bad     = (f3 > 3'd2);
                dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_BRANCH: begin
                u1      = 1'b1;
                u2      = 1'b1;
                bad     = (f3[2:1] == 2'b01);
                dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            end
            OPC_JALR: begin
                u1  = 1'b1;
                wr  = 1'b1;
                bad = (f3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                wr      = 1'b1;
                dec.imm = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                wr      = 1'b1;
                dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                // funct12 of 0x000/0x001 (ECALL/EBREAK) means bits [31:21] are all zero
                u1  = (f3[2] == 1'b0) && (f3[1:0] != 2'b00);
                wr  = (f3 != 3'd0);
                bad = (f3 == 3'd4) || (f3 == 3'd0 && in_inst[31:21] != 11'd0);
            end
            OPC_FENCE: ;
            default: bad = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) bad = 1'b1;

        dec.pc        = in_pc;
        dec.opcode    = op;
        dec.rd        = in_inst[11:7];
        dec.rs1       = in_inst[19:15];
        dec.rs2       = in_inst[24:20];
        dec.funct3    = f3;
        dec.funct7    = f7;
        dec.illegal   = (CHECK_ILLEGAL != 0) && bad;
        dec.uses_rs1  = u1 && !dec.illegal;
        dec.uses_rs2  = u2 && !dec.illegal;
        dec.writes_rd = wr && (in_inst[11:7] != 5'd0) && !dec.illegal;
    end

    assign acc  = in_valid && in_ready && !flush;
    assign emit = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != TWO);
            if (load_main) main_q <= main_nxt;
            if (load_skid) skid_q <= dec;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
                ONE: begin
                    if (acc && emit) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (emit) begin
                    state_nxt      = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
        main_nxt = main_from_skid ? skid_q : dec;
    end

    always_comb begin
        out_valid     = (state != EMPTY);
        out_pc        = main_q.pc;
        out_opcode    = main_q.opcode;
        out_rd        = main_q.rd;
        out_rs1       = main_q.rs1;
        out_rs2       = main_q.rs2;
        out_funct3    = main_q.funct3;
        out_funct7    = main_q.funct7;
        out_imm       = main_q.imm;
        out_uses_rs1  = main_q.uses_rs1;
        out_uses_rs2  = main_q.uses_rs2;
        out_writes_rd = main_q.writes_rd;
        out_illegal   = main_q.illegal;
    end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: accepted instructions are queued, a negedge
// monitor compares the DUT head entry against a behavioural decode model.
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [31:0] in_pc, in_inst;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_pc, b_out_imm;
    logic [6:0]  b_out_opcode, b_out_funct7;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [2:0]  b_out_funct3;
    logic        b_out_uses_rs1, b_out_uses_rs2, b_out_writes_rd, b_out_illegal;

    always #5 clk = ~clk;

    rv32i_decode_stage #(.CHECK_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_writes_rd(out_writes_rd), .out_illegal(out_illegal), .flush(flush)
    );

    rv32i_decode_stage #(.CHECK_ILLEGAL(0)) dut_nochk (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
        .out_uses_rs1(b_out_uses_rs1), .out_uses_rs2(b_out_uses_rs2),
        .out_writes_rd(b_out_writes_rd), .out_illegal(b_out_illegal), .flush(flush)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;

    typedef struct packed {
        logic [31:0] imm;
        logic        ill;
        logic        u1;
        logic        u2;
        logic        wr;
    } exp_t;

    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17,
                                        7'h6F, 7'h67, 7'h63, 7'h73, 7'h0F};

    txn_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rand_ready = 1'b0;
    bit          prev_rst = 1'b1;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: immediates built arithmetically from weighted bit groups.
    function automatic exp_t model(input logic [31:0] w, input bit chk);
        exp_t       e;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int         sgn = w[31] ? -1 : 0;
        bit         ill = 1'b0;
        case (op)
            7'h23:        e.imm = 32'(sgn * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
            7'h63:        e.imm = 32'(sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                                      + int'(w[11:8]) * 2);
            7'h37, 7'h17: e.imm = w & 32'hFFFF_F000;
            7'h6F:        e.imm = 32'(sgn * 1048576 + int'(w[19:12]) * 4096
                                      + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default:      e.imm = 32'(sgn * 2048 + int'(w[30:20]));
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
        case (op)
            7'h03: if (f3 inside {3'd3, 3'd6, 3'd7}) ill = 1'b1;
            7'h23: if (f3 > 3'd2) ill = 1'b1;
            7'h63: if (f3 inside {3'd2, 3'd3}) ill = 1'b1;
            7'h67: if (f3 != 3'd0) ill = 1'b1;
            7'h73: if (f3 == 3'd4 || (f3 == 3'd0 && !(w[31:20] inside {12'h000, 12'h001}))) ill = 1'b1;
            7'h33: if (!(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))) ill = 1'b1;
            7'h13: if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}))) ill = 1'b1;
            7'h37, 7'h17, 7'h6F, 7'h0F: ;
            default: ill = 1'b1;
        endcase
        e.ill = chk && ill;
        e.u1 = !e.ill && ((op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) ||
                          (op == 7'h73 && f3 inside {3'd1, 3'd2, 3'd3}));
        e.u2 = !e.ill && (op inside {7'h33, 7'h23, 7'h63});
        e.wr = !e.ill && (w[11:7] != 5'd0) &&
               ((op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) ||
                (op == 7'h73 && f3 != 3'd0));
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0] = OPS[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w[31:20] = 12'($urandom_range(0, 1));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Call at posedge+1; returns at posedge+1 after the transfer (or the flush).
    task automatic send(input logic [31:0] inst, input bit do_flush);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc_ctr;
        flush    = do_flush;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (flush) begin
                tick();
                flush    = 1'b0;
                in_valid = 1'b0;
                pc_ctr   = pc_ctr + 4;
                return;
            end
            if (in_ready) begin
                tick();
                sb_q.push_back(txn_t'{inst, pc_ctr});
                in_valid = 1'b0;
                pc_ctr   = pc_ctr + 4;
                return;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready never high for inst 0x%08h", inst);
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        txn_t t;
        exp_t e, e0;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_out_pc", out_pc, 0);
                check("rst_out_imm", out_imm, 0);
                check("rst_out_opcode", out_opcode, 0);
                check("rst_flags", {out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}, 0);
            end else begin
                check("out_valid", out_valid, sb_q.size() != 0);
                check("in_ready", in_ready, sb_q.size() < 2);
                check("b_out_valid", b_out_valid, sb_q.size() != 0);
                if (sb_q.size() != 0) begin
                    t  = sb_q[0];
                    e  = model(t.inst, 1'b1);
                    e0 = model(t.inst, 1'b0);
                    check("out_pc", out_pc, t.pc);
                    check("out_opcode", out_opcode, t.inst[6:0]);
                    check("out_rd", out_rd, t.inst[11:7]);
                    check("out_rs1", out_rs1, t.inst[19:15]);
                    check("out_rs2", out_rs2, t.inst[24:20]);
                    check("out_funct3", out_funct3, t.inst[14:12]);
                    check("out_funct7", out_funct7, t.inst[31:25]);
                    check("out_imm", out_imm, e.imm);
                    check("out_illegal", out_illegal, e.ill);
                    check("out_uses_rs1", out_uses_rs1, e.u1);
                    check("out_uses_rs2", out_uses_rs2, e.u2);
                    check("out_writes_rd", out_writes_rd, e.wr);
                    check("b_out_pc", b_out_pc, t.pc);
                    check("b_out_illegal", b_out_illegal, 0);
                    check("b_flags", {b_out_uses_rs1, b_out_uses_rs2, b_out_writes_rd},
                          {e0.u1, e0.u2, e0.wr});
                    if (out_ready && !flush && !rst) void'(sb_q.pop_front());
                end
            end
            if (rst || flush) sb_q.delete();
            prev_rst = rst;
        end
    end

    initial begin : stimulus
        logic [31:0] illegal_vec [3];
        illegal_vec[0] = 32'hFFFF_FFFF;
        illegal_vec[1] = 32'h0000_3003;
        illegal_vec[2] = 32'h4000_1033;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        send(32'h0050_0093, 1'b0);
        @(negedge clk);
        check("addi_opcode", out_opcode, 32'h13);
        check("addi_rd", out_rd, 1);
        check("addi_rs1", out_rs1, 0);
        check("addi_imm", out_imm, 32'h0000_0005);
        check("addi_flags", {out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal}, 4'b1010);
        tick();

        send(32'hFE00_0EE3, 1'b0);
        @(negedge clk);
        check("beq_imm", out_imm, 32'hFFFF_FFFC);
        check("beq_flags", {out_uses_rs1, out_uses_rs2, out_writes_rd}, 3'b110);
        tick();
        send(32'hFFDF_F0EF, 1'b0);
        @(negedge clk);
        check("jal_imm", out_imm, 32'hFFFF_FFFC);
        check("jal_writes_rd", out_writes_rd, 1);
        tick();

        for (int i = 0; i < 3; i++) begin
            send(illegal_vec[i], 1'b0);
            @(negedge clk);
            check("illegal_flag", out_illegal, 1);
            check("illegal_writes_rd", out_writes_rd, 0);
            check("nochk_illegal", b_out_illegal, 0);
            tick();
        end

        // Back-to-back A,B,C with the consumer stalled: C must wait for a free slot.
        out_ready = 1'b0;
        send(gen(), 1'b0);
        send(gen(), 1'b0);
        fork
            send(gen(), 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();

        out_ready = 1'b0;
        send(gen(), 1'b0);
        send(gen(), 1'b0);
        send(gen(), 1'b1);
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        send(gen(), 1'b0);
        repeat (4) tick();

        out_ready = 1'b0;
        send(gen(), 1'b0);
        send(gen(), 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_inst = gen();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        tick();
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;
        repeat (4) tick();

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(gen(), $urandom_range(0, 19) == 0);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("drain_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_stage.md
RV32I_DECODE_STAGE -- requirements
Module: rv32i_decode_stage

Interface
REQ-001 SHALL have parameter CHECK_ILLEGAL, default 1: 1 = full RV32I legality check; 0 = out_illegal tied 0.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_pc input 32, in_inst input 32: fetch-side handshake, PC, raw instruction word.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1, out_pc output 32: execute-side handshake and PC.
REQ-006 SHALL have ports out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_funct3 3, out_funct7 7, out_imm 32 (all outputs): decoded fields.
REQ-007 SHALL have outputs out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal (1 each): operand/legality flags.
REQ-008 SHALL have port flush  input  1  discard all buffered instructions.

Function
REQ-009 Transfer SHALL occur on any edge where valid && ready; valid and payload SHALL stay stable until the transfer.
REQ-010 Latency: instruction accepted at edge N SHALL appear on out_* from edge N onward (out_valid high in cycle N+1) when the buffer was empty.
REQ-011 Two-entry buffer (main + skid), occupancy states EMPTY, ONE, TWO; in_ready SHALL be driven from a register: 1 in EMPTY/ONE, 0 in TWO.
REQ-012 Transitions: accept only -> count+1; emit only -> count-1; accept and emit together -> count unchanged; TWO->ONE on emit moves skid to main.
REQ-013 Outputs SHALL always present the oldest buffered instruction; order SHALL be strictly FIFO.
REQ-014 Fields: opcode=inst[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25], passed through regardless of type.
REQ-015 Immediate: S (STORE) = sext(inst[31:25],inst[11:7]); B (BRANCH) = sext(inst[31],inst[7],inst[30:25],inst[11:8],0); U (LUI, AUIPC) = inst[31:12],12'b0; J (JAL) = sext(inst[31],inst[19:12],inst[20],inst[30:21],0); all others I = sext(inst[31:20]); sign source SHALL be inst[31] in every case.
REQ-016 uses_rs1 SHALL be 1 for OP, IMM, LOAD, STORE, BRANCH, JALR, and SYSTEM with funct3 in {1,2,3}; else 0.
REQ-017 uses_rs2 SHALL be 1 for OP, STORE, BRANCH only.
REQ-018 writes_rd SHALL be 1 for OP, IMM, LOAD, LUI, AUIPC, JAL, JALR, SYSTEM funct3!=0, and SHALL be 0 if rd==0 or illegal.
REQ-019 Illegal (CHECK_ILLEGAL=1) when: inst[1:0]!=2'b11; opcode not among OP 0x33, IMM 0x13, LOAD 0x03, STORE 0x23, LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, SYSTEM 0x73, FENCE 0x0F; LOAD funct3 in {3,6,7}; STORE funct3>2; BRANCH funct3 in {2,3}; JALR funct3!=0; SYSTEM funct3==4; SYSTEM funct3==0 with funct12 not 0x000/0x001; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; IMM funct3==1 with funct7!=0; IMM funct3==5 with funct7 not 0x00/0x20.
REQ-020 Illegal instructions SHALL still be emitted in order with out_illegal=1, uses_rs1/uses_rs2/writes_rd=0.
REQ-021 flush SHALL set occupancy to EMPTY at that edge, drop any same-cycle input (no transfer counted), and suppress the same-cycle output transfer; in_ready SHALL be 1 next cycle.
REQ-022 Decode SHALL be combinational on in_inst and registered into the buffer; no decode logic on the out_* path.

Reset
REQ-023 While rst high at an edge: occupancy EMPTY, out_valid=0, in_ready=0, all out_* data/flag registers 0.
REQ-024 First edge after rst low: in_ready=1; rst SHALL override flush and any handshake, including mid-stream with TWO entries held.

Verification
REQ-025 in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_opcode=0x13, rd=1, rs1=0, imm=0x00000005, uses_rs1=1, uses_rs2=0, writes_rd=1, illegal=0.
REQ-026 in 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, uses_rs1=1, uses_rs2=1, writes_rd=0; in 0xFFDFF0EF (jal x1,-4) -> out_imm=0xFFFFFFFC, writes_rd=1.
REQ-027 out_ready=0, three back-to-back inputs A,B,C -> A,B accepted, in_ready=0 from cycle after B, C held; out_ready=1 -> A,B,C emitted in order, no loss or duplicate.
REQ-028 Buffer in TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and same-cycle instructions never emitted.
REQ-029 in 0xFFFFFFFF, 0x00003003 (load funct3=3), 0x40001033 (funct7=0x20 with sll) -> each out_illegal=1, writes_rd=0; CHECK_ILLEGAL=0 -> out_illegal=0.
REQ-030 rst asserted one cycle while TWO held and out_ready=0 -> out_valid=0 and in_ready=0 that cycle, in_ready=1 next, no stale entry emitted.
